scan_loader: RTL and testbench

Serializer that drives the configuration scan chain from a parallel word source. Accepts WORD_W-bit words over a valid/ready handshake and shifts exactly CHAIN_LEN bits MSB-first onto the chain's serial input, with a one-cycle shift strobe per bit. It sits between the host/config bus and the chain. The chain is loaded in window → shift → mux_en → twiddle order; the host supplies the words in that order. An optional readback checker verifies the bits returning from the chain's serial output against the previous load.

---
 rtl/scan_loader_if.sv | 11 +
 rtl/scan_loader.sv | 122 ++++++++++++
 tb/tb_scan_loader.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/scan_loader_if.sv
// scan_loader_if: word handshake between host and scan_loader
//   wr_valid : host has a word
//   wr_data  : config word, MSB shifted first
//   wr_ready : loader accepts the word this cycle
interface scan_loader_if #(parameter int WORD_W = 32) ();
  logic              wr_valid;
  logic [WORD_W-1:0] wr_data;
  logic              wr_ready;
  modport master (output wr_valid, wr_data, input wr_ready);
  modport slave (input wr_valid, wr_data, output wr_ready);
endinterface

// File: rtl/scan_loader.sv
// scan_loader: serializes host words MSB-first onto the configuration scan chain
//   clk_scan, rst(async, active-high) ; start -> busy/done ; wr (slave handshake)
//   scan_data/scan_shift drive the chain, scan_ret returns from it
//   readback_valid/readback_ok: CRC readback check, built only with SCAN_LOADER_READBACK_EN
module scan_loader #(
  parameter int CHAIN_LEN = 11848,
  parameter int WORD_W    = 32,
  parameter int CLK_DIV   = 4
) (
  input  logic         clk_scan,
  input  logic         rst,
  input  logic         start,
  output logic         busy,
  output logic         done,
  output logic         scan_data,
  output logic         scan_shift,
  input  logic         scan_ret,
  output logic         readback_valid,
  output logic         readback_ok,
  scan_loader_if.slave wr
);
  localparam int RW = $clog2(CHAIN_LEN + 1);
  localparam int BW = $clog2(WORD_W + 1);
  localparam int DW = $clog2(CLK_DIV);
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  state_t            state, state_next;
  logic [RW-1:0]     remaining, remaining_next;
  logic [BW-1:0]     word_bits, word_bits_next;
  logic [DW-1:0]     div_cnt, div_cnt_next;
  logic [WORD_W-1:0] sreg, sreg_next;
  assign busy        = state != IDLE;
  assign done        = state == DONE;
  assign wr.wr_ready = state == FETCH;
  assign scan_shift  = state == SHIFT && div_cnt == DW'(CLK_DIV - 1);
  always_comb begin
    state_next     = state;
    remaining_next = remaining;
    word_bits_next = word_bits;
    div_cnt_next   = div_cnt;
    sreg_next      = sreg;
    case (state)
      IDLE: begin
        remaining_next = RW'(CHAIN_LEN);
        if (start) state_next = FETCH;
      end
      FETCH: if (wr.wr_valid) begin
        state_next     = SHIFT;
        sreg_next      = wr.wr_data;
        // a partial last word only contributes its upper `remaining` bits
        word_bits_next = 32'(remaining) < WORD_W ? BW'(remaining) : BW'(WORD_W);
        div_cnt_next   = '0;
      end
      SHIFT: if (scan_shift) begin
        sreg_next      = sreg << 1;
        remaining_next = remaining - 1'b1;
        word_bits_next = word_bits - 1'b1;
        div_cnt_next   = '0;
        if (word_bits == BW'(1)) state_next = remaining == RW'(1) ? DONE : FETCH;
      end else begin
        div_cnt_next = div_cnt + 1'b1;
      end
      default: state_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      remaining <= RW'(CHAIN_LEN);
      word_bits <= '0;
      div_cnt   <= '0;
      sreg      <= '0;
      scan_data <= 1'b0;
    end else begin
      state     <= state_next;
      remaining <= remaining_next;
      word_bits <= word_bits_next;
      div_cnt   <= div_cnt_next;
      sreg      <= sreg_next;
      // flopped so the chain sees a glitch-free bit for the whole divider window
      scan_data <= state_next == SHIFT && sreg_next[WORD_W-1];
    end
  end
`ifdef SCAN_LOADER_READBACK_EN
  logic [15:0] tx_crc, rx_crc, prev_tx_crc;
  logic        prev_loaded;
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction
  always_ff @(posedge clk_scan or posedge rst) begin
    if (rst) begin
      tx_crc         <= 16'hFFFF;
      rx_crc         <= 16'hFFFF;
      prev_tx_crc    <= 16'hFFFF;
      prev_loaded    <= 1'b0;
      readback_valid <= 1'b0;
      readback_ok    <= 1'b0;
    end else begin
      if (state == IDLE && start) begin
        tx_crc <= 16'hFFFF;
        rx_crc <= 16'hFFFF;
      end else if (scan_shift) begin
        tx_crc <= crc_step(tx_crc, scan_data);
        rx_crc <= crc_step(rx_crc, scan_ret);
      end
      // the chain is a FIFO, so this load's returned stream is the previous load's sent stream
      if (done) begin
        if (prev_loaded) begin
          readback_ok    <= rx_crc == prev_tx_crc;
          readback_valid <= 1'b1;
        end
        prev_tx_crc <= tx_crc;
        prev_loaded <= 1'b1;
      end
    end
  end
`else
  logic unused_ret;
  assign unused_ret     = scan_ret;
  assign readback_valid = 1'b0;
  assign readback_ok    = 1'b0;
`endif
endmodule

// File: tb/tb_scan_loader.sv
// tb_scan_loader: directed checks of scan_loader (small 40-bit chain and default build)
module tb_scan_loader;
`ifdef SCAN_LOADER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  logic s_start = 1'b0, s_busy, s_done, s_data, s_shift, s_ret, s_rv, s_ok;
  scan_loader_if #(.WORD_W(32)) s_if ();
  scan_loader #(.CHAIN_LEN(40), .WORD_W(32), .CLK_DIV(2)) s_dut (
    .clk_scan(clk), .rst(rst), .start(s_start), .busy(s_busy), .done(s_done),
    .scan_data(s_data), .scan_shift(s_shift), .scan_ret(s_ret),
    .readback_valid(s_rv), .readback_ok(s_ok), .wr(s_if.slave));
  logic d_start = 1'b0, d_busy, d_done, d_data, d_shift, d_rv, d_ok;
  logic d_ret = 1'b0;
  scan_loader_if #(.WORD_W(32)) d_if ();
  scan_loader d_dut (
    .clk_scan(clk), .rst(rst), .start(d_start), .busy(d_busy), .done(d_done),
    .scan_data(d_data), .scan_shift(d_shift), .scan_ret(d_ret),
    .readback_valid(d_rv), .readback_ok(d_ok), .wr(d_if.slave));
  logic [63:0] cap = '0;
  logic [39:0] chain = '0;
  int nbits = 0, hs = 0, ndone = 0, hs_cyc = 0, lat = 0, last_sh = 0, done_cyc = 0, stall_sh = 0;
  bit sh_pend = 1'b0, stall_on = 1'b0, flip = 1'b0;
  assign s_ret = chain[39];
  always @(posedge clk) begin
    if (s_shift) begin
      cap     <= {cap[62:0], s_data};
      nbits   <= nbits + 1;
      last_sh <= cyc;
      if (stall_on) stall_sh <= stall_sh + 1;
      if (sh_pend) begin
        lat     <= cyc - hs_cyc;
        sh_pend <= 1'b0;
      end
    end
    if (s_if.wr_valid && s_if.wr_ready) begin
      hs      <= hs + 1;
      hs_cyc  <= cyc;
      sh_pend <= 1'b1;
    end
    if (s_done) begin
      ndone    <= ndone + 1;
      done_cyc <= cyc;
    end
    if (rst) chain <= '0;
    else if (flip) chain[5] <= ~chain[5];
    else if (s_shift) chain <= {chain[38:0], s_data};
  end
  logic [39:0] d_cap = '0;
  int d_bits = 0, d_hs = 0, d_ndone = 0;
  always @(posedge clk) begin
    if (d_shift) begin
      d_cap  <= {d_cap[38:0], d_data};
      d_bits <= d_bits + 1;
    end
    if (d_if.wr_valid && d_if.wr_ready) d_hs <= d_hs + 1;
    if (d_done) d_ndone <= d_ndone + 1;
  end
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] w, input int stall);
    int n = 0;
    while (!s_if.wr_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 64'(s_if.wr_ready), 64'd1);
    stall_on = 1'b1;
    repeat (stall) @(negedge clk);
    stall_on = 1'b0;
    s_if.wr_valid = 1'b1;
    s_if.wr_data  = w;
    @(negedge clk);
    s_if.wr_valid = 1'b0;
  endtask
  task automatic wait_done();
    int n = 0;
    while (!s_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("done_wait", 64'(s_done), 64'd1);
    @(negedge clk);
    check("idle_after_done", 64'(s_busy), 64'd0);
  endtask
  task automatic small_load(input logic [31:0] w0, input logic [31:0] w1, input int stall, input bit poke);
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    check("fetch_after_start", 64'({s_busy, s_if.wr_ready}), 64'b11);
    send(w0, 0);
    if (poke) begin
      s_start = 1'b1;
      @(negedge clk);
      s_start = 1'b0;
    end
    send(w1, stall);
    wait_done();
  endtask
  initial begin
    int b0, h0, n0, n;
    s_if.wr_valid = 1'b0;
    s_if.wr_data  = '0;
    d_if.wr_valid = 1'b0;
    d_if.wr_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_outs_small", 64'({s_busy, s_done, s_if.wr_ready, s_data, s_shift, s_rv, s_ok}), 64'd0);
    check("reset_outs_dflt", 64'({d_busy, d_done, d_if.wr_ready, d_data, d_shift, d_rv, d_ok}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    b0 = nbits; h0 = hs; n0 = ndone;
    small_load(32'hA5A5_F00F, 32'hC312_3456, 0, 1'b0);
    check("l1_bits", cap[39:0], 40'hA5A5F00FC3);
    check("l1_count", 64'(nbits - b0), 64'd40);
    check("l1_handshakes", 64'(hs - h0), 64'd2);
    check("l1_done_once", 64'(ndone - n0), 64'd1);
    check("l1_done_lat", 64'(done_cyc - last_sh), 64'd1);
    check("l1_first_shift_lat", 64'(lat), 64'd2);
    check("l1_readback", 64'({s_rv, s_ok}), 64'd0);
    b0 = nbits; h0 = hs;
    small_load(32'h1234_5678, 32'h9A00_0000, 10, 1'b0);
    check("l2_bits", cap[39:0], 40'h123456789A);
    check("l2_count", 64'(nbits - b0), 64'd40);
    check("l2_handshakes", 64'(hs - h0), 64'd2);
    check("l2_stall_shifts", 64'(stall_sh), 64'd0);
    check("l2_readback", 64'({s_rv, s_ok}), 64'({RB, RB}));
    flip = 1'b1;
    @(negedge clk);
    flip = 1'b0;
    small_load(32'hDEAD_BEEF, 32'h01FF_FFFF, 0, 1'b0);
    check("l3_bits", cap[39:0], 40'hDEADBEEF01);
    check("l3_readback", 64'({s_rv, s_ok}), 64'({RB, 1'b0}));
    s_start = 1'b1;
    @(negedge clk);
    s_start = 1'b0;
    b0 = nbits;
    send(32'h55AA_55AA, 0);
    n = 0;
    while (nbits - b0 < 17 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("l4_17_bits", 64'(nbits - b0), 64'd17);
    rst = 1'b1;
    @(negedge clk);
    check("l4_reset_outs", 64'({s_busy, s_done, s_if.wr_ready, s_data, s_shift, s_rv, s_ok}), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    check("l4_idle", 64'({s_busy, s_if.wr_ready}), 64'd0);
    b0 = nbits;
    small_load(32'hA5A5_F00F, 32'hC300_0000, 0, 1'b0);
    check("l5_bits", cap[39:0], 40'hA5A5F00FC3);
    check("l5_count", 64'(nbits - b0), 64'd40);
    check("l5_readback", 64'({s_rv, s_ok}), 64'd0);
    h0 = hs;
    s_if.wr_valid = 1'b1;
    s_if.wr_data  = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    s_if.wr_valid = 1'b0;
    check("idle_valid_ignored", 64'({s_busy, 32'(hs - h0)}), 64'd0);
    b0 = nbits; n0 = ndone;
    small_load(32'h0F0F_0F0F, 32'h8000_0000, 0, 1'b1);
    check("l6_bits", cap[39:0], 40'h0F0F0F0F80);
    check("l6_count", 64'(nbits - b0), 64'd40);
    check("l6_handshakes", 64'(hs - h0), 64'd2);
    check("l6_done_once", 64'(ndone - n0), 64'd1);
    check("l6_readback", 64'({s_rv, s_ok}), 64'({RB, RB}));
    d_start = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    n0 = 0;
    for (int k = 0; k < 371; k++) begin
      n = 0;
      while (!d_if.wr_ready && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!d_if.wr_ready) n0++;
      d_if.wr_valid = 1'b1;
      d_if.wr_data  = {8'(k), 24'h5A5A5A};
      @(negedge clk);
      d_if.wr_valid = 1'b0;
    end
    check("dflt_ready_timeouts", 64'(n0), 64'd0);
    n = 0;
    while (!d_done && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("dflt_done", 64'(d_done), 64'd1);
    @(negedge clk);
    check("dflt_bits", 64'(d_bits), 64'd11848);
    check("dflt_handshakes", 64'(d_hs), 64'd371);
    check("dflt_tail", 64'(d_cap), 64'h71_5A5A5A_72);
    check("dflt_done_once", 64'(d_ndone), 64'd1);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
